// File: rtl/noc_vc_link_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : noc_vc_link_buffer_if
//  Brief    : Flit bus bundle for the VC link buffer (input side and output side)
//  Revision : 1.0
// ============================================================================
interface noc_vc_link_buffer_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int VCHANNELS  = 3
);
  logic [FLIT_WIDTH-1:0] in_flit;
  logic [VCHANNELS-1:0]  in_valid;
  logic [VCHANNELS-1:0]  in_ready;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic [VCHANNELS-1:0]  out_valid;
  logic [VCHANNELS-1:0]  out_ready;

  // Buffer side
  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );

  // Environment side: upstream producer plus downstream consumer
  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/noc_vc_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : noc_vc_link_buffer
//  Brief    : Per-VC flit FIFOs with a wormhole-locking round-robin output arbiter
//  Revision : 1.0
// ============================================================================
module noc_vc_link_buffer #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VCHANNELS       = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_vc_link_buffer_if.slave   link
);
  localparam int c_flit_width = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
  localparam int c_ptr_width  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_width  = c_ptr_width + 1;
  localparam int c_vc_width   = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  localparam logic [c_cnt_width-1:0]     c_depth       = c_cnt_width'(FIFO_DEPTH);
  localparam logic [c_vc_width-1:0]      c_last_vc     = c_vc_width'(VCHANNELS - 1);
  localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_header = FLIT_TYPE_WIDTH'(2'b01);
  localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_last   = FLIT_TYPE_WIDTH'(2'b10);
  localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_single = FLIT_TYPE_WIDTH'(2'b11);

  logic [c_flit_width-1:0] r_mem [VCHANNELS][FIFO_DEPTH];
  logic [c_ptr_width-1:0]  r_wr_ptr [VCHANNELS];
  logic [c_ptr_width-1:0]  r_rd_ptr [VCHANNELS];
  logic [c_cnt_width-1:0]  r_count  [VCHANNELS];
  logic                    r_lock;
  logic [c_vc_width-1:0]   r_sel;
  logic [c_vc_width-1:0]   r_rr;

  logic [VCHANNELS-1:0]       w_ready;
  logic [VCHANNELS-1:0]       w_push_hit;
  logic [VCHANNELS-1:0]       w_pop_hit;
  logic [VCHANNELS-1:0]       w_valid;
  logic                       w_push_en;
  logic [c_vc_width-1:0]      w_push_vc;
  logic                       w_out_en;
  logic [c_vc_width-1:0]      w_out_vc;
  logic                       w_pop;
  int                         w_scan_idx;
  logic [c_flit_width-1:0]    w_head;
  logic [FLIT_TYPE_WIDTH-1:0] w_pop_type;

  // Ready looks only at registered occupancy, and is forced low during reset
  always_comb begin
    w_ready = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      w_ready[v] = !rst && (r_count[v] < c_depth);
    end
  end

  // The input bus is shared, so only the lowest requesting VC may push
  always_comb begin
    w_push_vc = '0;
    for (int v = VCHANNELS - 1; v >= 0; v--) begin
      if (link.in_valid[v]) begin
        w_push_vc = c_vc_width'(v);
      end
    end
    w_push_en = (|link.in_valid) && w_ready[w_push_vc];
  end

  // A locked packet owns the link, even while its FIFO is momentarily empty
  always_comb begin
    w_out_en   = 1'b0;
    w_out_vc   = r_sel;
    w_scan_idx = 0;
    if (r_lock) begin
      w_out_en = (r_count[r_sel] != '0);
    end else begin
      for (int i = 0; i < VCHANNELS; i++) begin
        w_scan_idx = int'(r_rr) + i;
        if (w_scan_idx >= VCHANNELS) begin
          w_scan_idx = w_scan_idx - VCHANNELS;
        end
        if (!w_out_en && (r_count[c_vc_width'(w_scan_idx)] != '0)) begin
          w_out_en = 1'b1;
          w_out_vc = c_vc_width'(w_scan_idx);
        end
      end
    end
  end

  assign w_head     = r_mem[w_out_vc][r_rd_ptr[w_out_vc]];
  assign w_pop      = w_out_en && link.out_ready[w_out_vc];
  assign w_pop_type = w_head[c_flit_width-1 -: FLIT_TYPE_WIDTH];

  always_comb begin
    w_valid    = '0;
    w_push_hit = '0;
    w_pop_hit  = '0;
    if (w_out_en) begin
      w_valid[w_out_vc] = 1'b1;
    end
    for (int v = 0; v < VCHANNELS; v++) begin
      w_push_hit[v] = w_push_en && (w_push_vc == c_vc_width'(v));
      w_pop_hit[v]  = w_pop && (w_out_vc == c_vc_width'(v));
    end
  end

  assign link.in_ready  = w_ready;
  assign link.out_valid = w_valid;
  assign link.out_flit  = w_out_en ? w_head : '0;

  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[w_push_vc][r_wr_ptr[w_push_vc]] <= link.in_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VCHANNELS; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VCHANNELS; v++) begin
        if (w_push_hit[v]) begin
          r_wr_ptr[v] <= r_wr_ptr[v] + c_ptr_width'(1);
        end
        if (w_pop_hit[v]) begin
          r_rd_ptr[v] <= r_rd_ptr[v] + c_ptr_width'(1);
        end
        if (w_push_hit[v] && !w_pop_hit[v]) begin
          r_count[v] <= r_count[v] + c_cnt_width'(1);
        end else if (!w_push_hit[v] && w_pop_hit[v]) begin
          r_count[v] <= r_count[v] - c_cnt_width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= 1'b0;
      r_sel  <= '0;
      r_rr   <= '0;
    end else if (w_pop) begin
      if (w_pop_type == c_type_header) begin
        r_lock <= 1'b1;
        r_sel  <= w_out_vc;
      end else if ((w_pop_type == c_type_last) || (w_pop_type == c_type_single)) begin
        r_lock <= 1'b0;
        r_rr   <= (w_out_vc == c_last_vc) ? '0 : w_out_vc + c_vc_width'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_noc_vc_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_vc_link_buffer
//  Brief    : Directed and random stimulus against a queue-based packet model
//  Revision : 1.0
// ============================================================================
module tb_noc_vc_link_buffer;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int VC    = 3;
  localparam int DEPTH = 4;
  localparam int FW    = DW + TW;

  localparam logic [TW-1:0] T_PAY = 2'b00;
  localparam logic [TW-1:0] T_HDR = 2'b01;
  localparam logic [TW-1:0] T_LST = 2'b10;
  localparam logic [TW-1:0] T_SGL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_vc_link_buffer_if #(.FLIT_WIDTH(FW), .VCHANNELS(VC)) link ();

  noc_vc_link_buffer #(
    .FLIT_DATA_WIDTH(DW),
    .FLIT_TYPE_WIDTH(TW),
    .VCHANNELS(VC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(link)
  );

  typedef logic [FW-1:0] flit_q_t[$];
  flit_q_t q [VC];
  bit      m_lock;
  int      m_sel;
  int      m_rr;
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [VC-1:0] v, input logic [TW-1:0] t,
                       input logic [DW-1:0] d, input logic [VC-1:0] r);
    link.in_valid  = v;
    link.in_flit   = {t, d};
    link.out_ready = r;
  endtask

  task automatic model_clear();
    for (int v = 0; v < VC; v++) q[v].delete();
    m_lock = 1'b0;
    m_sel  = 0;
    m_rr   = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then apply the edge to the model
  task automatic cycle();
    bit              any;
    int              idx;
    int              p;
    logic [VC-1:0]   exp_ready;
    logic [VC-1:0]   exp_valid;
    logic [FW-1:0]   exp_flit;
    logic [FW-1:0]   popped;
    logic [FW-1:0]   in_f;
    logic [VC-1:0]   in_v;
    logic [VC-1:0]   out_r;
    @(negedge clk);
    for (int v = 0; v < VC; v++) exp_ready[v] = (q[v].size() < DEPTH);
    any = 1'b0;
    idx = 0;
    if (m_lock) begin
      idx = m_sel;
      any = (q[m_sel].size() > 0);
    end else begin
      for (int i = 0; i < VC; i++) begin
        if (!any && q[(m_rr + i) % VC].size() > 0) begin
          any = 1'b1;
          idx = (m_rr + i) % VC;
        end
      end
    end
    exp_valid = '0;
    exp_flit  = '0;
    if (any) begin
      exp_valid[idx] = 1'b1;
      exp_flit       = q[idx][0];
    end
    check("in_ready",  link.in_ready,  exp_ready);
    check("out_valid", link.out_valid, exp_valid);
    check("out_flit",  link.out_flit,  exp_flit);
    in_f  = link.in_flit;
    in_v  = link.in_valid;
    out_r = link.out_ready;
    p = -1;
    for (int v = VC - 1; v >= 0; v--) if (in_v[v]) p = v;
    @(posedge clk);
    if (any && out_r[idx]) begin
      popped = q[idx].pop_front();
      if (popped[FW-1 -: TW] == T_HDR) begin
        m_lock = 1'b1;
        m_sel  = idx;
      end else if (popped[FW-1 -: TW] == T_LST || popped[FW-1 -: TW] == T_SGL) begin
        m_lock = 1'b0;
        m_rr   = (idx + 1) % VC;
      end
    end
    if (p >= 0 && exp_ready[p]) q[p].push_back(in_f);
    #1;
  endtask

  // Called just after a rising edge; outputs must clear without waiting for a clock
  task automatic do_reset();
    link.in_valid = '0;
    rst = 1'b1;
    #1;
    check("rst_out_valid", link.out_valid, '0);
    check("rst_out_flit",  link.out_flit,  '0);
    check("rst_in_ready",  link.in_ready,  '0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_in_ready", link.in_ready, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive('0, T_PAY, '0, '0);
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Single flit on vc1
    drive(3'b010, T_SGL, 32'hCAFE0001, 3'b111);
    cycle();
    drive(3'b000, T_PAY, 32'h0, 3'b111);
    cycle();
    cycle();

    // Fill vc0 with backpressure, attempt a fifth push, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, T_SGL, 32'h1000 + i, 3'b000);
      cycle();
    end
    drive(3'b000, T_PAY, 32'h0, 3'b001);
    repeat (6) cycle();

    // Wormhole lock with a mid-packet gap on vc0 while vc2 waits
    do_reset();
    drive(3'b001, T_HDR, 32'hA0, 3'b000); cycle();
    drive(3'b001, T_PAY, 32'hA1, 3'b000); cycle();
    drive(3'b100, T_SGL, 32'hC0, 3'b000); cycle();
    drive(3'b000, T_PAY, 32'h0,  3'b111); cycle();
    cycle();
    drive(3'b001, T_LST, 32'hA2, 3'b111); cycle();
    drive(3'b000, T_PAY, 32'h0,  3'b111);
    repeat (3) cycle();

    // Round robin across three VCs, each holding two singles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(VC'(1 << (i % VC)), T_SGL, 32'h200 + i, 3'b000);
      cycle();
    end
    drive(3'b000, T_PAY, 32'h0, 3'b111);
    repeat (7) cycle();

    // Backpressure on a selected vc1 single
    drive(3'b010, T_SGL, 32'hBEEF, 3'b101); cycle();
    drive(3'b000, T_PAY, 32'h0,    3'b101);
    repeat (5) cycle();
    drive(3'b000, T_PAY, 32'h0,    3'b111);
    repeat (2) cycle();

    // Reset after a header has left, then a vc2 single must pass normally
    do_reset();
    drive(3'b001, T_HDR, 32'hD0, 3'b000); cycle();
    drive(3'b001, T_PAY, 32'hD1, 3'b000); cycle();
    drive(3'b000, T_PAY, 32'h0,  3'b001); cycle();
    do_reset();
    drive(3'b100, T_SGL, 32'hE0, 3'b111); cycle();
    drive(3'b000, T_PAY, 32'h0,  3'b111);
    repeat (2) cycle();

    // Random traffic including multi-bit in_valid and mixed flit types
    for (int n = 0; n < 400; n++) begin
      logic [VC-1:0] v;
      logic [VC-1:0] r;
      v = VC'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) v = '0;
      r = ($urandom_range(0, 2) == 0) ? VC'($urandom_range(0, 7)) : '1;
      drive(v, TW'($urandom_range(0, 3)), $urandom, r);
      cycle();
    end
    drive(3'b000, T_PAY, 32'h0, 3'b111);
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/noc_vc_link_buffer.md
NOC_VC_LINK_BUFFER -- requirements
Module: noc_vc_link_buffer

Interface
REQ-001 Parameter flit_data_width, default 32, flit payload width in bits.
REQ-002 Parameter flit_type_width, default 2, flit type field width in bits; type occupies the flit MSBs.
REQ-003 Parameter vchannels, default 3, number of virtual channels.
REQ-004 Parameter fifo_depth, default 4, flits per vchannel FIFO; power of two, minimum 2.
REQ-005 Local flit_width = flit_data_width+flit_type_width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_flit  input  flit_width  shared input flit bus (driven by a tile's noc_out_flit).
REQ-009 in_valid  input  vchannels  per-vchannel valid for in_flit.
REQ-010 in_ready  output  vchannels  per-vchannel ready.
REQ-011 out_flit  output  flit_width  shared output flit bus (drives a link or a tile's noc_in_flit).
REQ-012 out_valid  output  vchannels  per-vchannel valid, at most one bit set.
REQ-013 out_ready  input  vchannels  per-vchannel ready from downstream.

Function
REQ-014 Flit types: 2'b01 header, 2'b00 payload, 2'b10 last, 2'b11 single.
REQ-015 One FIFO per vchannel, with registered read/write pointers and an occupancy counter of width clog2(fifo_depth)+1.
REQ-016 in_ready[v] is 1 iff occupancy[v] < fifo_depth; computed from registered count only, so a same-cycle pop does not re-enable a full FIFO.
REQ-017 Push into FIFO v occurs when in_valid[v] && in_ready[v]; if several in_valid bits are set, only the lowest set index is accepted and the rest are ignored.
REQ-018 No fall-through: a flit pushed at edge N is first visible on out_flit in the cycle after edge N (1-cycle minimum latency).
REQ-019 Output arbiter state: lock flag, locked vchannel index sel, round-robin pointer rr.
REQ-020 Unlocked: select the first non-empty vchannel scanning rr, rr+1, ... modulo vchannels; out_valid[sel]=1, out_flit = head of FIFO sel.
REQ-021 Locked: only vchannel sel is eligible; if FIFO sel is empty, out_valid=0 and no other vchannel is served.
REQ-022 Pop of FIFO sel occurs when out_valid[sel] && out_ready[sel].
REQ-023 Popping a header sets lock to sel; popping last or single clears lock and sets rr=(sel+1) mod vchannels; popping payload leaves lock unchanged.
REQ-024 While unlocked, payload or last flits are forwarded as received; last additionally updates rr as in REQ-023.
REQ-025 out_flit is all-zero when no out_valid bit is set.
REQ-026 Simultaneous push and pop on the same FIFO: occupancy unchanged, both pointers advance.
REQ-027 Pointers wrap modulo fifo_depth; no overflow or underflow is possible under REQ-016 and REQ-022.
REQ-028 out_valid must not drop without a transfer while locked and FIFO sel is non-empty (valid is held stable under backpressure).

Reset
REQ-029 On rst assertion, asynchronously: all FIFOs empty, lock=0, rr=0, out_valid=0, out_flit=0.
REQ-030 While rst is high, in_ready=0 and no push occurs; in_ready goes to all-ones in the first cycle after rst deasserts.
REQ-031 rst asserted mid-packet discards all buffered flits and the lock; there is no partial-packet recovery.

Verification
REQ-032 Single flit: push {2'b11,32'hCAFE0001} on vc1 at cycle 0, out_ready=3'b111 -> out_valid=3'b010 with that flit at cycle 1, FIFO empty at cycle 2.
REQ-033 Fill: push 4 flits on vc0 with out_ready=0 -> in_ready[0]=0 after the 4th push; a 5th in_valid is not accepted; out_ready[0]=1 then drains in FIFO order, 1 flit per cycle.
REQ-034 Wormhole lock: a vc0 packet (header, payload, last) and a vc2 single are both queued -> vc0's 3 flits are output contiguously, vc2 follows; a vc0 gap mid-packet yields out_valid=0, not vc2.
REQ-035 Round robin: all 3 vchannels continuously hold single flits, rr=0 -> output order vc0, vc1, vc2, vc0, ...
REQ-036 Backpressure: out_ready[1]=0 for 5 cycles with vc1 selected -> out_valid and out_flit stable throughout; the transfer completes on the cycle ready rises.
REQ-037 Reset mid-packet: rst pulses after a header is popped -> all outputs 0 immediately, FIFOs empty, and the next vc2 single is output normally after rst deasserts.
